// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Owner tags for in-flight responses and the byte-to-word shift.
package mem_arb_pkg;
   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_D
   } owner_t;

   localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM bundle for mem_port_arbiter.
// The arbiter takes the slave view; the core and RAM side take master.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                       if_req;
   logic [ADDR_W-1:0]          if_addr;
   logic                       if_gnt;
   logic                       if_rvalid;
   logic [DATA_W-1:0]          if_rdata;

   logic                       d_req;
   logic                       d_we;
   logic [ADDR_W-1:0]          d_addr;
   logic [DATA_W-1:0]          d_wdata;
   logic                       d_gnt;
   logic                       d_rvalid;
   logic [DATA_W-1:0]          d_rdata;
   logic                       d_err;

   logic                       mem_en;
   logic                       mem_we;
   logic [ADDR_W-WORD_SHIFT-1:0] mem_addr;
   logic [DATA_W-1:0]          mem_wdata;
   logic [DATA_W-1:0]          mem_rdata;

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: data has priority, fetch is forced after
// STARVE_MAX consecutive data wins; responses routed one cycle later.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);

   logic [3:0]        r_starve_cnt;
   owner_t            r_pend_owner;
   logic              r_pend_err;
   logic              r_pend_we;

   logic              w_if_gnt;
   logic              w_d_gnt;
   logic              w_mis;
   logic              w_if_rv;
   logic              w_d_rv;
   logic [ADDR_W-1:0] w_addr;
   logic              w_unused;

   // Grants are forced low during reset so every output reads 0.
   always_comb begin
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
      if (!rst) begin
         if (bus.if_req && (r_starve_cnt == LP_MAX))
            w_if_gnt = 1'b1;
         else if (bus.d_req)
            w_d_gnt = 1'b1;
         else if (bus.if_req)
            w_if_gnt = 1'b1;
      end
   end

   assign w_mis = w_d_gnt &&
                  (bus.d_addr[WORD_SHIFT-1:0] != '0);

   always_comb begin
      w_addr = '0;
      if (w_d_gnt)
         w_addr = bus.d_addr;
      else if (w_if_gnt)
         w_addr = bus.if_addr;
   end

   assign w_unused = ^bus.if_addr[WORD_SHIFT-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve_cnt <= '0;
         r_pend_owner <= OWN_NONE;
         r_pend_err   <= 1'b0;
         r_pend_we    <= 1'b0;
      end else begin
         if (w_if_gnt)
            r_pend_owner <= OWN_IF;
         else if (w_d_gnt)
            r_pend_owner <= OWN_D;
         else
            r_pend_owner <= OWN_NONE;
         r_pend_err <= w_mis;
         r_pend_we  <= w_d_gnt && bus.d_we;
         if (w_if_gnt || !bus.if_req)
            r_starve_cnt <= '0;
         else if (w_d_gnt && (r_starve_cnt != LP_MAX))
            r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

   assign bus.if_gnt    = w_if_gnt;
   assign bus.d_gnt     = w_d_gnt;
   assign bus.mem_en    = w_if_gnt || (w_d_gnt && !w_mis);
   assign bus.mem_we    = w_d_gnt && bus.d_we;
   assign bus.mem_addr  = w_addr[ADDR_W-1:WORD_SHIFT];
   assign bus.mem_wdata = rst ? '0 : bus.d_wdata;

   assign w_if_rv = (r_pend_owner == OWN_IF);
   assign w_d_rv  = (r_pend_owner == OWN_D);

   assign bus.if_rvalid = w_if_rv;
   assign bus.if_rdata  = w_if_rv ? bus.mem_rdata : '0;
   assign bus.d_rvalid  = w_d_rv;
   assign bus.d_err     = w_d_rv && r_pend_err;
   // Stores and misaligned accesses return zero data.
   assign bus.d_rdata   = (w_d_rv && !r_pend_err && !r_pend_we) ?
                          bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, reference arbiter model
// checked every cycle, plus literal expectations from directed cases.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SMAX = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic logic [31:0] rdef(input logic [29:0] w);
      return 32'hA500_0000 ^ {2'b00, w};
   endfunction

   // RAM environment
   logic [31:0] ram [logic [29:0]];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we)
            ram[bus.mem_addr] = bus.mem_wdata;
         else
            bus.mem_rdata <= ram.exists(bus.mem_addr) ?
                             ram[bus.mem_addr] : rdef(bus.mem_addr);
      end
   end

   int rst_edges = 0;
   always @(posedge rst) rst_edges++;

   // Reference model state
   logic [31:0] shadow [logic [29:0]];
   int          wins;
   int          exp_own;
   logic        exp_err;
   logic [31:0] exp_data;
   int          seen_rst;
   int          n_chk;
   int          n_pass;

   function automatic logic [31:0] sread(input logic [29:0] w);
      return shadow.exists(w) ? shadow[w] : rdef(w);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  nm, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic model_check();
      logic        e_if, e_d, e_mis, e_en, e_we;
      logic [29:0] w;
      if (rst) begin
         chk("rst_if_gnt", bus.if_gnt, 0);
         chk("rst_d_gnt", bus.d_gnt, 0);
         chk("rst_mem_en", bus.mem_en, 0);
         chk("rst_mem_we", bus.mem_we, 0);
         chk("rst_mem_addr", bus.mem_addr, 0);
         chk("rst_mem_wdata", bus.mem_wdata, 0);
         chk("rst_if_rvalid", bus.if_rvalid, 0);
         chk("rst_if_rdata", bus.if_rdata, 0);
         chk("rst_d_rvalid", bus.d_rvalid, 0);
         chk("rst_d_rdata", bus.d_rdata, 0);
         chk("rst_d_err", bus.d_err, 0);
         wins    = 0;
         exp_own = 0;
         return;
      end
      if (rst_edges != seen_rst) begin
         seen_rst = rst_edges;
         wins     = 0;
         exp_own  = 0;
      end
      chk("m_if_rvalid", bus.if_rvalid, exp_own == 1);
      chk("m_if_rdata", bus.if_rdata, exp_own == 1 ? exp_data : 0);
      chk("m_d_rvalid", bus.d_rvalid, exp_own == 2);
      chk("m_d_err", bus.d_err, exp_own == 2 && exp_err);
      chk("m_d_rdata", bus.d_rdata, exp_own == 2 ? exp_data : 0);

      e_if  = bus.if_req && (wins >= SMAX || !bus.d_req);
      e_d   = bus.d_req && !e_if;
      e_mis = e_d && (bus.d_addr[1:0] != 2'b00);
      e_en  = e_if || (e_d && !e_mis);
      e_we  = e_d && bus.d_we;
      chk("m_if_gnt", bus.if_gnt, e_if);
      chk("m_d_gnt", bus.d_gnt, e_d);
      chk("m_mem_en", bus.mem_en, e_en);
      chk("m_mem_we", bus.mem_we, e_we);
      w = e_if ? bus.if_addr[31:2] : bus.d_addr[31:2];
      if (e_en)
         chk("m_mem_addr", bus.mem_addr, w);
      if (e_en && e_we)
         chk("m_mem_wdata", bus.mem_wdata, bus.d_wdata);

      exp_err  = 1'b0;
      exp_data = '0;
      if (e_if) begin
         exp_own  = 1;
         exp_data = sread(w);
      end else if (e_d) begin
         exp_own = 2;
         exp_err = e_mis;
         if (!e_mis) begin
            if (bus.d_we)
               shadow[w] = bus.d_wdata;
            else
               exp_data = sread(w);
         end
      end else begin
         exp_own = 0;
      end

      if (!bus.if_req || e_if)
         wins = 0;
      else if (e_d)
         wins++;
   endtask

   task automatic set_in(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dwd);
      bus.if_req  = ir;
      bus.if_addr = ia;
      bus.d_req   = dr;
      bus.d_we    = dwe;
      bus.d_addr  = da;
      bus.d_wdata = dwd;
   endtask

   task automatic chk_cyc();
      @(negedge clk);
      model_check();
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk    = 0;
      n_pass   = 0;
      wins     = 0;
      exp_own  = 0;
      exp_err  = 1'b0;
      exp_data = '0;
      seen_rst = 0;
      rst      = 1'b1;
      set_in(1, 32'h100, 1, 1, 32'h200, 32'h1234_5678);
      chk_cyc();
      nxt();
      chk_cyc();
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      nxt();

      // Fetch only
      for (int i = 0; i < 4; i++) begin
         set_in(i < 3, 32'h100, 0, 0, 0, 0);
         chk_cyc();
         if (i < 3) chk("t1_mem_addr", bus.mem_addr, 30'h40);
         if (i > 0) chk("t1_if_rdata", bus.if_rdata, 32'hA500_0040);
         nxt();
      end

      // Load/fetch contention
      for (int i = 0; i < 11; i++) begin
         set_in(i < 10, 32'h104, i < 10, 0, 32'h200, 0);
         chk_cyc();
         if (i < 10) chk("t2_if_gnt", bus.if_gnt, i == 4 || i == 9);
         if (i == 1) chk("t2_d_rdata", bus.d_rdata, 32'hA500_0080);
         if (i == 5) chk("t2_if_rdata", bus.if_rdata, 32'hA500_0041);
         nxt();
      end

      // Store then load
      set_in(0, 0, 1, 1, 32'h20, 32'hDEAD_BEEF);
      chk_cyc();
      chk("t3_mem_we", bus.mem_we, 1);
      chk("t3_mem_addr", bus.mem_addr, 30'h8);
      nxt();
      set_in(0, 0, 1, 0, 32'h20, 0);
      chk_cyc();
      chk("t3_st_rvalid", bus.d_rvalid, 1);
      chk("t3_st_rdata", bus.d_rdata, 0);
      nxt();
      set_in(0, 0, 0, 0, 0, 0);
      chk_cyc();
      chk("t3_ld_rdata", bus.d_rdata, 32'hDEAD_BEEF);
      nxt();

      // Misaligned load
      set_in(0, 0, 1, 0, 32'h203, 0);
      chk_cyc();
      chk("t4_d_gnt", bus.d_gnt, 1);
      chk("t4_mem_en", bus.mem_en, 0);
      nxt();
      set_in(0, 0, 0, 0, 0, 0);
      chk_cyc();
      chk("t4_d_rvalid", bus.d_rvalid, 1);
      chk("t4_d_err", bus.d_err, 1);
      chk("t4_d_rdata", bus.d_rdata, 0);
      nxt();
      for (int i = 0; i < 6; i++) begin
         set_in(i < 5, 32'h108, i < 5, 0, 32'h202, 0);
         chk_cyc();
         if (i == 4) chk("t4_force_if", bus.if_gnt, 1);
         nxt();
      end

      // Reset during an outstanding fetch
      set_in(1, 32'h10C, 0, 0, 0, 0);
      chk_cyc();
      nxt();
      chk_cyc();
      chk("t5_if_gnt", bus.if_gnt, 1);
      #2;
      set_in(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      chk("t5_rst_if_rvalid", bus.if_rvalid, 0);
      chk("t5_rst_if_rdata", bus.if_rdata, 0);
      chk("t5_rst_mem_en", bus.mem_en, 0);
      #1;
      rst = 1'b0;
      nxt();
      chk_cyc();
      chk("t5_no_rvalid", bus.if_rvalid, 0);
      nxt();
      for (int i = 0; i < 6; i++) begin
         set_in(i < 5, 32'h110, i < 5, 0, 32'h204, 0);
         chk_cyc();
         if (i < 5) chk("t5_resume_if_gnt", bus.if_gnt, i == 4);
         nxt();
      end

      // Idle gaps
      for (int i = 0; i < 8; i++) begin
         set_in(i % 2 == 0, 32'h114, i % 4 == 0, 0, 32'h208, 0);
         chk_cyc();
         nxt();
      end
      for (int i = 0; i < 10; i++) begin
         set_in(i < 9 && i != 3, 32'h118, i < 9, 0, 32'h20C, 0);
         chk_cyc();
         if (i == 7) chk("t6_no_force", bus.if_gnt, 0);
         if (i == 8) chk("t6_force_if", bus.if_gnt, 1);
         nxt();
      end
      chk_cyc();
      nxt();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
